// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle N-bit shift controller driving an external
// single-bit shifter through a feedback accumulator.
// Optional feature macro: SHIFT_SEQ_EARLY_EXIT_EN -- when defined, a SHIFT
// sequence ends as soon as the shifter output stops changing (fixed point).
module shift_sequencer #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [AMT_W-1:0]  amount,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] sh_in,
  output logic [1:0]        sh_shift,
  input  logic [DATA_W-1:0] sh_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [AMT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        sh_shift_q, sh_shift_d;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = din;
          op_d  = op;
          cnt_d = amount;
          // Nothing to iterate: report the operand straight away.
          if ((amount == '0) || (op == 2'b00)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        acc_d = sh_out;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = S_DONE;
        end
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        // Further steps cannot change a value the shifter maps onto itself.
        else if (sh_out == acc_q) begin
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    sh_shift_d = (state_d == S_SHIFT) ? op_d : 2'b00;
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      op_q       <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sh_shift_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sh_shift_q <= sh_shift_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign dout     = acc_q;
  assign sh_in    = acc_q;
  assign sh_shift = sh_shift_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: a stimulus process issues directed and random
// requests and queues the expected result/latency; a monitor process checks
// every done pulse and the per-cycle shifter control against that queue.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [3:0]  amount = 4'd0;
  logic [15:0] din = 16'h0000;
  logic        busy, done;
  logic [15:0] dout, sh_in, sh_out;
  logic [1:0]  sh_shift;

  shift_sequencer #(.DATA_W(16), .AMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .amount(amount),
    .din(din), .busy(busy), .done(done), .dout(dout), .sh_in(sh_in),
    .sh_shift(sh_shift), .sh_out(sh_out)
  );

  always #5 clk = ~clk;

  // Single-bit shifter model sitting on the DUT's shifter port.
  always_comb begin
    case (sh_shift)
      2'b01:   sh_out = {sh_in[14:0], 1'b0};
      2'b10:   sh_out = {1'b0, sh_in[15:1]};
      2'b11:   sh_out = {sh_in[15], sh_in[15:1]};
      default: sh_out = sh_in;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int          lat;
    int          start_cyc;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          passed = 0;
  int          txn_id = 0;
  logic [1:0]  cur_op = 2'b00;
  logic [15:0] last_result = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference: N-bit shift expressed with whole-word operators.
  function automatic logic [15:0] ref_shift(input logic [15:0] x, input logic [1:0] o, input int n);
    case (o)
      2'b01:   return x << n;
      2'b10:   return x >> n;
      2'b11:   return 16'($signed(x) >>> n);
      default: return x;
    endcase
  endfunction

  // Reference latency from acceptance edge to the done cycle.
  function automatic int ref_latency(input logic [15:0] x, input logic [1:0] o, input int n);
    int steps;
    if (n == 0 || o == 2'b00) return 1;
    steps = n;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    for (int i = 1; i <= n; i++) begin
      if (ref_shift(x, o, i) == ref_shift(x, o, i - 1)) begin
        steps = i;
        break;
      end
    end
`endif
    return steps + 1;
  endfunction

  // Monitor: scoreboard pop on done, control/hold checks every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("dout_txn%0d", e.id), 32'(dout), 32'(e.data));
          check($sformatf("latency_txn%0d", e.id), 32'(cyc - e.start_cyc), 32'(e.lat));
          last_result = e.data;
          $display("txn %0d: dout=0x%04h exp=0x%04h latency=%0d exp=%0d",
                   e.id, dout, e.data, cyc - e.start_cyc, e.lat);
        end
      end
      if (busy && !done) check("sh_shift_active", 32'(sh_shift), 32'(cur_op));
      else               check("sh_shift_idle", 32'(sh_shift), 32'd0);
      if (!busy)         check("dout_hold", 32'(dout), 32'(last_result));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 64) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one request; returns at T+1 (one step after the acceptance edge).
  task automatic issue(input logic [15:0] d, input logic [1:0] o, input logic [3:0] n, input bit pulse_mid);
    exp_t e;
    wait_idle();
    e.data      = ref_shift(d, o, int'(n));
    e.lat       = ref_latency(d, o, int'(n));
    e.start_cyc = cyc;
    e.id        = txn_id++;
    exp_q.push_back(e);
    din = d; op = o; amount = n; start = 1'b1;
    cur_op = o;
    @(posedge clk); #1;
    start = 1'b0;
    din = 16'($urandom); op = 2'($urandom); amount = 4'($urandom);
    if (pulse_mid && e.lat > 2) begin
      din = ~d; op = ~o; amount = 4'd15; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_sh_shift", 32'(sh_shift), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    issue(16'hF0CF, 2'b01, 4'd1, 1'b0);
    issue(16'hF0CF, 2'b01, 4'd4, 1'b0);
    issue(16'hF0CF, 2'b10, 4'd4, 1'b0);
    issue(16'hF0CF, 2'b11, 4'd4, 1'b0);
    issue(16'hF0CF, 2'b10, 4'd0, 1'b0);
    issue(16'hF0CF, 2'b00, 4'd7, 1'b0);
    issue(16'h1234, 2'b01, 4'd6, 1'b1);
    issue(16'h0001, 2'b10, 4'd15, 1'b0);
    issue(16'h8000, 2'b11, 4'd15, 1'b0);

    // Reset during cycle T+2 of an 8-step shift.
    issue(16'hA5C3, 2'b01, 4'd8, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    cur_op = 2'b00;
    last_result = 16'h0000;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_sh_shift", 32'(sh_shift), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      logic [15:0] d;
      int sel;
      sel = int'($urandom_range(0, 7));
      d = (sel == 0) ? 16'h0001 : (sel == 1) ? 16'hFFFF : (sel == 2) ? 16'h8000 : 16'($urandom);
      issue(d, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
